// File: rtl/out_sa_deskew.sv
// out_sa_deskew: realigns skewed systolic-array row outputs into whole vectors.
// Each row has its own small FIFO. A vector is presented once every row holds
// at least one entry, and all rows pop together on o_valid && i_ready.
// Optional build macro OUT_SA_DESKEW_CNT_EN adds o_vec_count, a 16-bit
// wrapping count of accepted vectors.
module out_sa_deskew #(
    parameter int unsigned ROW   = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [9*ROW-1:0]     i_row_data,
    output logic [8*ROW-1:0]     o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overflow
`ifdef OUT_SA_DESKEW_CNT_EN
    ,
    output logic [15:0]          o_vec_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [7:0]    mem_q  [ROW][DEPTH];
    logic [7:0]    mem_d  [ROW][DEPTH];
    logic [PW-1:0] rptr_q [ROW];
    logic [PW-1:0] rptr_d [ROW];
    logic [PW-1:0] wptr_q [ROW];
    logic [PW-1:0] wptr_d [ROW];
    logic [CW-1:0] cnt_q  [ROW];
    logic [CW-1:0] cnt_d  [ROW];
    logic          ovf_q;
    logic          ovf_d;
    logic [ROW-1:0] push_c;
    logic [ROW-1:0] drop_c;
    logic          pop_c;
    logic          all_ne_c;

    // A vector is complete only when no row FIFO is empty
    always_comb begin
        all_ne_c = 1'b1;
        for (int r = 0; r < int'(ROW); r++) begin
            if (cnt_q[r] == '0) all_ne_c = 1'b0;
        end
    end

    // Head of every row forms the output; zero while no full vector is present
    always_comb begin
        o_data  = '0;
        o_valid = all_ne_c;
        for (int r = 0; r < int'(ROW); r++) begin
            if (all_ne_c) o_data[8*(ROW-r)-1 -: 8] = mem_q[r][rptr_q[r]];
        end
    end

    assign pop_c      = all_ne_c & i_ready;
    assign o_overflow = ovf_q;

    // Per-row push is allowed when not full, or when full but popping this cycle
    always_comb begin
        push_c = '0;
        drop_c = '0;
        for (int r = 0; r < int'(ROW); r++) begin
            if (i_row_data[9*(ROW-r)-1]) begin
                if (cnt_q[r] != FULL || pop_c) push_c[r] = 1'b1;
                else                           drop_c[r] = 1'b1;
            end
        end
    end

    // Next-state for FIFO storage, pointers, counts and the sticky overflow
    always_comb begin
        mem_d = mem_q;
        ovf_d = ovf_q | (|drop_c);
        for (int r = 0; r < int'(ROW); r++) begin
            rptr_d[r] = rptr_q[r];
            wptr_d[r] = wptr_q[r];
            cnt_d[r]  = cnt_q[r];
            if (push_c[r]) begin
                mem_d[r][wptr_q[r]] = i_row_data[9*(ROW-r)-2 -: 8];
                wptr_d[r] = wptr_q[r] + PW'(1);
            end
            if (pop_c) rptr_d[r] = rptr_q[r] + PW'(1);
            if (push_c[r] && !pop_c)      cnt_d[r] = cnt_q[r] + CW'(1);
            else if (!push_c[r] && pop_c) cnt_d[r] = cnt_q[r] - CW'(1);
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
            for (int r = 0; r < int'(ROW); r++) begin
                rptr_q[r] <= '0;
                wptr_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int r = 0; r < int'(ROW); r++) begin
                rptr_q[r] <= rptr_d[r];
                wptr_q[r] <= wptr_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    // FIFO storage; contents are don't-care while the matching count is zero
    always_ff @(posedge i_clk) begin
        for (int r = 0; r < int'(ROW); r++) begin
            for (int d = 0; d < int'(DEPTH); d++) begin
                mem_q[r][d] <= mem_d[r][d];
            end
        end
    end

`ifdef OUT_SA_DESKEW_CNT_EN
    logic [15:0] vec_cnt_q;
    logic [15:0] vec_cnt_d;

    // Accepted-vector counter, wraps naturally at 16 bits
    always_comb begin
        vec_cnt_d = vec_cnt_q;
        if (pop_c) vec_cnt_d = vec_cnt_q + 16'd1;
    end

    // Counter register
    always_ff @(posedge i_clk) begin
        if (i_rst) vec_cnt_q <= '0;
        else       vec_cnt_q <= vec_cnt_d;
    end

    assign o_vec_count = vec_cnt_q;
`endif

endmodule

// File: doc/out_sa_deskew.md
OUT_SA_DESKEW -- requirements
Module: out_sa_deskew

Interface
REQ-001 The block SHALL have parameter ROW, default 8, giving the number of systolic-array rows collected.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving per-row FIFO entries (power of two, >= 2).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have port i_row_data, input, 9*ROW, per-row {valid,data[7:0]} slices; row i SHALL occupy bits [9*(ROW-i)-1 -: 9], with bit 8 of each slice as valid.
REQ-006 The block SHALL have port o_data, output, 8*ROW, the aligned vector; row i SHALL occupy bits [8*(ROW-i)-1 -: 8].
REQ-007 The block SHALL have port o_valid, output, 1, asserted when o_data holds a complete aligned vector.
REQ-008 The block SHALL have port i_ready, input, 1, the downstream accept signal.
REQ-009 The block SHALL have port o_overflow, output, 1, a sticky flag set when any row's data is dropped.

Function
REQ-010 Each row SHALL own an independent DEPTH-entry FIFO with read pointer, write pointer and occupancy count (0..DEPTH).
REQ-011 A row's FIFO SHALL be pushed with data[7:0] in every cycle where that row's valid bit is 1 and the FIFO is not full, or is full and being popped in the same cycle.
REQ-012 Skew absorption: rows SHALL be pushed independently, with no ordering assumed between rows.
REQ-013 o_valid SHALL be 1 iff every row FIFO has count >= 1; o_data SHALL be the head entry of every row FIFO, driven combinationally from the FIFO heads.
REQ-014 A pop of all row FIFOs together SHALL occur iff o_valid && i_ready; there SHALL be no partial pops.
REQ-015 Latency: a slice pushed in cycle N SHALL first be visible at o_data in cycle N+1, provided all other rows are non-empty.
REQ-016 Simultaneous push and pop on a row SHALL leave its count unchanged and SHALL be legal at both full and empty.
REQ-017 A push to a full row FIFO with no pop in that cycle SHALL drop the input, leave the FIFO unchanged, and set o_overflow in the next cycle.
REQ-018 o_overflow SHALL remain 1 until reset.
REQ-019 Pointers SHALL wrap modulo DEPTH.
REQ-020 o_data SHALL be held stable while o_valid=1 and i_ready=0.

Reset
REQ-021 While i_rst=1 at a clock edge, all pointers and counts SHALL clear to 0, o_overflow SHALL clear to 0, and input slices in that cycle SHALL be ignored.
REQ-022 After reset, o_valid SHALL be 0 and o_data SHALL be 0 until the first complete vector is available.
REQ-023 A reset asserted mid-operation SHALL discard all buffered entries, with no vector emitted from pre-reset data.

Configuration
REQ-024 With macro OUT_SA_DESKEW_CNT_EN defined, the block SHALL add port o_vec_count, output, 16, counting accepted vectors (o_valid && i_ready), resetting to 0 and wrapping from 0xFFFF to 0.
REQ-025 Without OUT_SA_DESKEW_CNT_EN, o_vec_count and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 ROW=8 with i_ready=1: rows 0..7 each get one valid slice, row i skewed by i cycles, with data=0x10+i -> a single o_valid pulse one cycle after row 7's push, with o_data=0x1011121314151617.
REQ-027 Skewed stream of 3 vectors with i_ready=0 held for 6 cycles -> o_valid stays 1, o_data stays equal to vector 0, and vectors then emerge in order once i_ready=1.
REQ-028 Row 0 gets 5 pushes (DEPTH=4) while row 7 stays empty -> 5th push is dropped, o_overflow=1 next cycle and stays 1, and the FIFO keeps entries 1..4.
REQ-029 All rows full with i_ready=1 and a simultaneous push on every row -> no overflow, counts remain 4, and the output advances by one vector.
REQ-030 i_rst pulsed with 2 entries buffered in some rows -> next cycle o_valid=0, o_overflow=0, and o_vec_count=0 when OUT_SA_DESKEW_CNT_EN is defined.
REQ-031 With OUT_SA_DESKEW_CNT_EN defined, 65537 accepted vectors -> o_vec_count=1.
